pps_discipline_ctrl: RTL and testbench

- Sequencing controller for the PPS clock-error measurement path.
- Validates the GPS 1PPS, measures each PPS period in system clocks and publishes the signed error over a valid/ready handshake (consumer: UART report formatter).
- Tracks lock, detects missing PPS and runs a flywheel second tick in holdover.

---
 rtl/pps_discipline_ctrl_if.sv | 19 +
 rtl/pps_discipline_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pps_discipline_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pps_discipline_ctrl_if.sv
// pps_discipline_ctrl_if: signed error-sample valid/ready bus
// from the PPS discipline controller to the report formatter.
interface pps_discipline_ctrl_if;
  logic        err_valid;
  logic        err_ready;
  logic [31:0] err_data;

  modport master (
    output err_valid,
    output err_data,
    input  err_ready
  );

  modport slave (
    input  err_valid,
    input  err_data,
    output err_ready
  );
endinterface

// File: rtl/pps_discipline_ctrl.sv
// pps_discipline_ctrl: PPS period measurement, lock tracking, holdover flywheel.
// Define PPS_AVG_EN to publish block averages of 2**AVG_LOG2 seconds.
module pps_discipline_ctrl #(
  parameter int unsigned CLOCK_PER_SECOND = 10_000_000,
  parameter int unsigned TOL              = 1000,
  parameter int unsigned LOCK_COUNT       = 3
`ifdef PPS_AVG_EN
  ,
  parameter int unsigned AVG_LOG2         = 2
`endif
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         pps,
  input  logic                         enable,
  pps_discipline_ctrl_if.master        err,
  output logic                         locked,
  output logic                         holdover,
  output logic                         tick,
  output logic                         overrun,
  output logic [7:0]                   missing_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    ACQUIRE,
    LOCKED,
    HOLDOVER
  } state_t;

  localparam logic [31:0] CPS   = 32'(CLOCK_PER_SECOND);
  localparam logic [31:0] T_OUT = 32'(CLOCK_PER_SECOND + TOL);
  localparam logic [31:0] T_FLY = 32'(CLOCK_PER_SECOND - 1);
  localparam logic [31:0] TOLV  = 32'(TOL);
  localparam logic [7:0]  LCK_N = 8'(LOCK_COUNT);

  state_t      state, state_n;
  logic        last_pps;
  logic [31:0] cnt, cnt_n;
  logic [7:0]  good_cnt, good_n;
  logic        edge_det, good;
  logic        sample, fly, tmo;
  logic        pub;
  logic [31:0] period, err_e, abs_e, pub_data;
  logic        valid_q;
  logic [31:0] data_q;

  assign edge_det = pps & ~last_pps;
  assign period   = cnt + 32'd1;
  assign err_e    = period - CPS;
  assign abs_e    = err_e[31] ? (~err_e + 32'd1) : err_e;
  assign good     = (abs_e <= TOLV);

  assign locked   = (state == LOCKED);
  assign holdover = (state == HOLDOVER);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    good_n  = good_cnt;
    sample  = 1'b0;
    fly     = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (enable) state_n = SEEK;
      end
      SEEK: begin
        cnt_n = '0;
        if (edge_det) begin
          state_n = ACQUIRE;
          good_n  = '0;
        end
      end
      ACQUIRE, LOCKED: begin
        if (edge_det) begin
          sample = 1'b1;
          cnt_n  = '0;
          if (!good) begin
            good_n  = '0;
            state_n = ACQUIRE;
          end else if (state == ACQUIRE) begin
            good_n = good_cnt + 8'd1;
            if (good_n == LCK_N) state_n = LOCKED;
          end
        end else if (cnt == T_OUT) begin
          // Missed second: edge in the same cycle would have won above
          tmo     = 1'b1;
          cnt_n   = '0;
          good_n  = '0;
          state_n = (state == LOCKED) ? HOLDOVER : SEEK;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      HOLDOVER: begin
        if (edge_det) begin
          state_n = ACQUIRE;
          cnt_n   = '0;
          good_n  = '0;
        end else if (cnt == T_FLY) begin
          fly   = 1'b1;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      good_n  = '0;
      sample  = 1'b0;
      fly     = 1'b0;
      tmo     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      last_pps    <= 1'b0;
      cnt         <= '0;
      good_cnt    <= '0;
      tick        <= 1'b0;
      missing_cnt <= '0;
    end else begin
      state    <= state_n;
      last_pps <= pps;
      cnt      <= cnt_n;
      good_cnt <= good_n;
      tick     <= sample | fly;
      if ((tmo | fly) && missing_cnt != 8'hFF)
        missing_cnt <= missing_cnt + 8'd1;
    end
  end

`ifdef PPS_AVG_EN
  localparam int          SW    = 32 + AVG_LOG2;
  localparam logic [7:0]  SLAST = 8'((1 << AVG_LOG2) - 1);

  logic signed [SW-1:0] sum_q, sum_acc;
  logic [7:0]           scnt_q;

  assign sum_acc  = sum_q + SW'($signed(err_e));
  assign pub      = sample & (scnt_q == SLAST);
  assign pub_data = 32'(sum_acc >>> AVG_LOG2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum_q  <= '0;
      scnt_q <= '0;
    end else if (state_n == IDLE || state_n == SEEK ||
                 state_n == HOLDOVER) begin
      sum_q  <= '0;
      scnt_q <= '0;
    end else if (sample) begin
      if (scnt_q == SLAST) begin
        sum_q  <= '0;
        scnt_q <= '0;
      end else begin
        sum_q  <= sum_acc;
        scnt_q <= scnt_q + 8'd1;
      end
    end
  end
`else
  assign pub      = sample;
  assign pub_data = err_e;
`endif

  // A publish never waits: an unconsumed sample is overwritten and flagged
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      overrun <= 1'b0;
    end else if (!enable) begin
      valid_q <= 1'b0;
      overrun <= 1'b0;
    end else if (pub) begin
      data_q  <= pub_data;
      valid_q <= 1'b1;
      if (valid_q && !err.err_ready) overrun <= 1'b1;
    end else if (valid_q && err.err_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign err.err_valid = valid_q;
  assign err.err_data  = data_q;

endmodule

// File: tb/tb_pps_discipline_ctrl.sv
// tb_pps_discipline_ctrl: directed and randomized PPS periods checked
// against a per-second behavioural model of lock, holdover and handshake.
module tb_pps_discipline_ctrl;
  localparam int CPS = 100;
  localparam int TOL = 2;
  localparam int LCK = 3;
  localparam int AVG_LOG2 = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pps = 1'b0;
  logic       enable = 1'b0;
  logic       locked, holdover, tick, overrun;
  logic [7:0] missing_cnt;

  pps_discipline_ctrl_if eif();

  pps_discipline_ctrl #(
    .CLOCK_PER_SECOND(CPS),
    .TOL(TOL),
    .LOCK_COUNT(LCK)
`ifdef PPS_AVG_EN
    ,
    .AVG_LOG2(AVG_LOG2)
`endif
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .pps(pps),
    .enable(enable),
    .err(eif),
    .locked(locked),
    .holdover(holdover),
    .tick(tick),
    .overrun(overrun),
    .missing_cnt(missing_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit          m_valid, m_ovr, m_locked, m_hold;
  int          m_good, m_missing;
  logic [31:0] m_data;
  int          acc, nacc;
  bit          rdy_rand = 1'b1;
  logic        wait_rdy = 1'b1;
  logic        pub_rdy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic avg_clear();
    acc = 0;
    nacc = 0;
  endtask

  task automatic set_rdy(input bit at_pub);
    if (rdy_rand) eif.err_ready = 1'($urandom_range(0, 1));
    else eif.err_ready = at_pub ? pub_rdy : wait_rdy;
  endtask

  task automatic clk_step(input bit pub, input logic [31:0] d);
    logic r;
    r = eif.err_ready;
    @(posedge clk);
    #1;
    if (pub) begin
      if (m_valid && !r) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data = d;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk_hs();
    chk("err_valid", eif.err_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    if (m_valid) chk("err_data", eif.err_data, m_data);
  endtask

  task automatic step(input bit exp_tick);
    set_rdy(1'b0);
    clk_step(1'b0, 32'd0);
    chk_hs();
    chk("tick", tick, exp_tick);
  endtask

  task automatic seek_pulse();
    set_rdy(1'b1);
    pps = 1'b1;
    clk_step(1'b0, 32'd0);
    pps = 1'b0;
    m_good = 0;
    m_locked = 1'b0;
    m_hold = 1'b0;
    chk_hs();
    chk("nosample_tick", tick, 0);
    chk("nosample_locked", locked, 0);
    chk("nosample_holdover", holdover, 0);
  endtask

  // One measured second of period p, edge on the last cycle
  task automatic second(input int p);
    int  e, d;
    bit  good, pub;
    repeat (p - 1) step(1'b0);
    e = p - CPS;
    good = (e >= -TOL) && (e <= TOL);
`ifdef PPS_AVG_EN
    acc += e;
    nacc++;
    pub = (nacc == (1 << AVG_LOG2));
    d = (acc >= 0) ? acc / (1 << AVG_LOG2)
                   : -((-acc + (1 << AVG_LOG2) - 1) / (1 << AVG_LOG2));
    if (pub) avg_clear();
`else
    pub = 1'b1;
    d = e;
`endif
    set_rdy(1'b1);
    pps = 1'b1;
    clk_step(pub, 32'(d));
    pps = 1'b0;
    if (m_locked) begin
      if (!good) begin
        m_locked = 1'b0;
        m_good = 0;
      end
    end else if (good) begin
      m_good++;
      if (m_good == LCK) m_locked = 1'b1;
    end else begin
      m_good = 0;
    end
    chk_hs();
    chk("sec_tick", tick, 1);
    chk("sec_locked", locked, m_locked);
    chk("sec_holdover", holdover, 0);
  endtask

  task automatic tmo_step(input bit to_hold);
    set_rdy(1'b0);
    clk_step(1'b0, 32'd0);
    if (m_missing < 255) m_missing++;
    m_good = 0;
    m_locked = 1'b0;
    m_hold = to_hold;
    avg_clear();
    chk_hs();
    chk("tmo_tick", tick, 0);
    chk("tmo_locked", locked, 0);
    chk("tmo_holdover", holdover, m_hold);
    chk("tmo_missing", missing_cnt, m_missing);
  endtask

  task automatic fly_tick();
    set_rdy(1'b0);
    clk_step(1'b0, 32'd0);
    if (m_missing < 255) m_missing++;
    chk_hs();
    chk("fly_tick", tick, 1);
    chk("fly_missing", missing_cnt, m_missing);
    chk("fly_holdover", holdover, 1);
  endtask

  task automatic disable_step();
    enable = 1'b0;
    set_rdy(1'b0);
    clk_step(1'b0, 32'd0);
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_locked = 1'b0;
    m_hold = 1'b0;
    m_good = 0;
    avg_clear();
    chk_hs();
    chk("dis_locked", locked, 0);
    chk("dis_holdover", holdover, 0);
    chk("dis_tick", tick, 0);
    chk("dis_missing", missing_cnt, m_missing);
    enable = 1'b1;
    step(1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, eif.err_valid, 0);
    chk({tag, "_data"}, eif.err_data, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_holdover"}, holdover, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_missing"}, missing_cnt, 0);
  endtask

  initial begin
    eif.err_ready = 1'b0;
    m_valid = 0; m_ovr = 0; m_locked = 0; m_hold = 0;
    m_good = 0; m_missing = 0; m_data = '0;
    avg_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst");
    resetn = 1'b1;

    // Enabled with no PPS: nothing happens
    enable = 1'b1;
    repeat (300) step(1'b0);
    chk("seek_missing", missing_cnt, 0);
    chk("seek_locked", locked, 0);

    // Nominal seconds lock after the third good sample
    rdy_rand = 1'b0; wait_rdy = 1'b1; pub_rdy = 1'b1;
    seek_pulse();
    repeat (3) second(100);
    chk("lock_4th_edge", locked, 1);

    // Drift inside tolerance keeps lock, outside drops it
    second(101);
    second(97);
    chk("drop_lock", locked, 0);
    repeat (3) second(100);

    // PPS loss from LOCKED: timeout, flywheel, recovery
    repeat (102) step(1'b0);
    chk("pre_tmo_locked", locked, 1);
    chk("pre_tmo_hold", holdover, 0);
    tmo_step(1'b1);
    for (int k = 0; k < 2; k++) begin
      repeat (99) step(1'b0);
      fly_tick();
    end
    repeat (40) step(1'b0);
    seek_pulse();
    chk("recover_missing", missing_cnt, m_missing);
    repeat (3) second(100);
    chk("relock", locked, 1);

    // PPS loss from ACQUIRE falls back to SEEK
    second(97);
    repeat (102) step(1'b0);
    tmo_step(1'b0);
    repeat (150) step(1'b0);
    seek_pulse();
    second(100);

    // Overrun, then same-cycle consume avoids it
    disable_step();
    seek_pulse();
    rdy_rand = 1'b0; wait_rdy = 1'b0; pub_rdy = 1'b0;
    second(101);
    second(99);
    disable_step();
    seek_pulse();
    second(101);
    pub_rdy = 1'b1;
    second(99);
    chk("no_overrun", overrun, 0);

    // Disable mid-LOCKED with a pending sample
    rdy_rand = 1'b1;
    disable_step();
    seek_pulse();
    repeat (3) second(100);
    rdy_rand = 1'b0; wait_rdy = 1'b0; pub_rdy = 1'b0;
    second(100);
    repeat (37) step(1'b0);
    disable_step();

    // Samples 1, 2, 3, -1
    seek_pulse();
    wait_rdy = 1'b1; pub_rdy = 1'b1;
    second(101); second(102); second(103); second(99);
`ifdef PPS_AVG_EN
    chk("avg_result", eif.err_data, 32'h0000_0001);
`else
    chk("last_sample", eif.err_data, 32'hFFFF_FFFF);
`endif

    // Randomized periods across the tolerance and timeout boundaries
    rdy_rand = 1'b1;
    disable_step();
    seek_pulse();
    for (int i = 0; i < 40; i++) second(int'($urandom_range(97, 103)));

    // Missing-second counter saturation in holdover
    repeat (3) second(100);
    repeat (102) step(1'b0);
    tmo_step(1'b1);
    for (int k = 0; k < 260; k++) begin
      repeat (99) step(1'b0);
      fly_tick();
    end
    chk("missing_sat", missing_cnt, 255);

    // Asynchronous reset mid-period
    repeat (30) step(1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_state("async_rst");
    m_valid = 0; m_ovr = 0; m_locked = 0; m_hold = 0;
    m_good = 0; m_missing = 0;
    avg_clear();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b0);
    chk("post_rst_missing", missing_cnt, 0);
    chk("post_rst_holdover", holdover, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
